// File: rtl/approx_pkg.sv
// Shared definitions for the approximate adder: mode encodings used by the
// combinational core, the pipeline and its handshake interface.
package approx_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_EXACT = 2'b00,
      MODE_LOA   = 2'b01,
      MODE_TRUNC = 2'b10,
      MODE_COPY  = 2'b11
   } mode_t;

endpackage

// File: rtl/approx_add_pipe_if.sv
// Operand/result handshake bundle for approx_add_pipe; the producer/consumer
// side uses master, the adder pipeline uses slave.
interface approx_add_pipe_if
   import approx_pkg::*;
#(
   parameter int W = 8
);

   logic [W-1:0]      A;
   logic [W-1:0]      B;
   logic [MODE_W-1:0] mode;
   logic              in_valid;
   logic              in_ready;
   logic [W:0]        O;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output A, B, mode, in_valid, out_ready,
      input  in_ready, O, out_valid
   );

   modport slave (
      input  A, B, mode, in_valid, out_ready,
      output in_ready, O, out_valid
   );

endinterface

// File: rtl/approx_add_pipe_core.sv
// Combinational approximate adder: exact, lower-part OR, truncate and
// operand-copy variants on the low K bits; usable on its own.
module approx_add_core
   import approx_pkg::*;
#(
   parameter int W = 8,
   parameter int K = 4
) (
   input  logic [W-1:0]      A,
   input  logic [W-1:0]      B,
   input  logic [MODE_W-1:0] mode,
   output logic [W:0]        O
);

   localparam int HW = W - K;

   logic [HW:0]  hi_sum;
   logic [K-1:0] lo;
   logic         cin;

   always_comb begin
      lo  = '0;
      cin = 1'b0;
      case (mode_t'(mode))
         MODE_LOA: begin
            lo  = A[K-1:0] | B[K-1:0];
            cin = A[K-1] & B[K-1];
         end
         MODE_COPY: lo = B[K-1:0];
         default:   ;
      endcase
      // Upper part is always a real adder; only its carry-in differs by mode.
      hi_sum = {1'b0, A[W-1:K]} + {1'b0, B[W-1:K]} + {{HW{1'b0}}, cin};
      if (mode_t'(mode) == MODE_EXACT) O = {1'b0, A} + {1'b0, B};
      else                            O = {hi_sum, lo};
   end

endmodule

// File: rtl/approx_add_pipe.sv
// Two-stage valid/ready pipeline around approx_add_core with running error
// statistics (sum, max, nonzero count, sample count) on every output transfer.
module approx_add_pipe
   import approx_pkg::*;
#(
   parameter int W    = 8,
   parameter int K    = 4,
   parameter int ACCW = 24
) (
   input  logic              clk,
   input  logic              rst_n,
   approx_add_pipe_if.slave  bus,
   input  logic              stat_clr,
   output logic [ACCW-1:0]   err_sum,
   output logic [W:0]        err_max,
   output logic [ACCW-1:0]   err_cnt,
   output logic [ACCW-1:0]   smp_cnt
);

   localparam int SW = ACCW + W + 2;

   function automatic logic [ACCW-1:0] sat_add(input logic [ACCW-1:0] base,
                                               input logic [W:0]      add);
      logic [SW-1:0] s;
      s = SW'(base) + SW'(add);
      if (s > SW'({ACCW{1'b1}})) return '1;
      return s[ACCW-1:0];
   endfunction

   function automatic logic [W:0] abs_diff(input logic [W:0] x, input logic [W:0] y);
      return (x >= y) ? (x - y) : (y - x);
   endfunction

   logic [W-1:0]      a_p1, b_p1;
   logic [MODE_W-1:0] mode_p1;
   logic              vld_p1, vld_p2;
   logic [W:0]        approx_p1, exact_p1, err_p1;
   logic [W:0]        o_p2, exact_p2, err_p2;
   logic              in_xfer, adv_p2, out_xfer;
   logic [ACCW-1:0]   sum_nx, cnt_nx, smp_nx;
   logic [W:0]        max_nx;

   assign out_xfer     = vld_p2 & bus.out_ready;
   assign adv_p2       = vld_p1 & (~vld_p2 | bus.out_ready);
   assign bus.in_ready = ~vld_p1 | adv_p2;
   assign in_xfer      = bus.in_valid & bus.in_ready;
   assign bus.O        = o_p2;
   assign bus.out_valid = vld_p2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_p1 <= 1'b0;
         vld_p2 <= 1'b0;
      end else begin
         vld_p1 <= in_xfer | (vld_p1 & ~adv_p2);
         vld_p2 <= adv_p2 | (vld_p2 & ~out_xfer);
      end
   end

   // Stage 1: operands and mode captured together, so in-flight work keeps its mode
   always_ff @(posedge clk) begin
      if (in_xfer) begin
         a_p1    <= bus.A;
         b_p1    <= bus.B;
         mode_p1 <= bus.mode;
      end
   end

   approx_add_core #(.W(W), .K(K)) u_core (
      .A    (a_p1),
      .B    (b_p1),
      .mode (mode_p1),
      .O    (approx_p1)
   );

   assign exact_p1 = {1'b0, a_p1} + {1'b0, b_p1};
   assign err_p1   = abs_diff(approx_p1, exact_p1);

   // Stage 2: result, reference sum and error held until the consumer takes them
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_p2     <= '0;
         exact_p2 <= '0;
         err_p2   <= '0;
      end else if (adv_p2) begin
         o_p2     <= approx_p1;
         exact_p2 <= exact_p1;
         err_p2   <= err_p1;
      end
   end

   // A clear in the same cycle as a transfer counts that transfer from zero.
   always_comb begin
      sum_nx = stat_clr ? '0 : err_sum;
      cnt_nx = stat_clr ? '0 : err_cnt;
      smp_nx = stat_clr ? '0 : smp_cnt;
      max_nx = stat_clr ? '0 : err_max;
      if (out_xfer) begin
         sum_nx = sat_add(sum_nx, err_p2);
         cnt_nx = sat_add(cnt_nx, (W+1)'(o_p2 != exact_p2));
         smp_nx = sat_add(smp_nx, (W+1)'(1));
         if (err_p2 > max_nx) max_nx = err_p2;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_sum <= '0;
         err_cnt <= '0;
         smp_cnt <= '0;
         err_max <= '0;
      end else begin
         err_sum <= sum_nx;
         err_cnt <= cnt_nx;
         smp_cnt <= smp_nx;
         err_max <= max_nx;
      end
   end

endmodule

// File: tb/tb_approx_add_pipe.sv
// Scoreboard bench for approx_add_pipe: directed vectors push expected sums,
// a monitor pops them on each output transfer and watches stall stability.
module tb_approx_add_pipe;
   import approx_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic stat_clr = 1'b0;
   logic [23:0] err_sum, err_cnt, smp_cnt;
   logic [8:0]  err_max;
   logic [3:0]  s_err_sum, s_err_cnt, s_smp_cnt;
   logic [8:0]  s_err_max;
   logic        s_stat_clr = 1'b0;

   int checks = 0;
   int errors = 0;
   logic [8:0] exp_q[$];
   logic       stall = 1'b0;
   logic [8:0] held = '0;
   logic       stream_done;

   approx_add_pipe_if #(.W(8)) bus ();
   approx_add_pipe_if #(.W(8)) sbus ();

   approx_add_pipe #(.W(8), .K(4), .ACCW(24)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus), .stat_clr(stat_clr),
      .err_sum(err_sum), .err_max(err_max), .err_cnt(err_cnt), .smp_cnt(smp_cnt)
   );

   approx_add_pipe #(.W(8), .K(4), .ACCW(4)) dut_sat (
      .clk(clk), .rst_n(rst_n), .bus(sbus), .stat_clr(s_stat_clr),
      .err_sum(s_err_sum), .err_max(s_err_max), .err_cnt(s_err_cnt), .smp_cnt(s_smp_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   task automatic send(input logic [7:0] a, input logic [7:0] b,
                       input logic [1:0] m, input logic [8:0] expo);
      bit ok;
      ok = 1'b0;
      @(negedge clk);
      bus.A = a; bus.B = b; bus.mode = m; bus.in_valid = 1'b1;
      for (int n = 0; n < 200; n++) begin
         #1;
         if (bus.in_ready) begin
            ok = 1'b1;
            exp_q.push_back(expo);
            break;
         end
         @(negedge clk);
      end
      if (!ok) chk("send_accept_timeout", 32'(ok), 32'd1);
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      bit ok;
      ok = 1'b0;
      for (int n = 0; n < 200; n++) begin
         @(negedge clk); #1;
         if (exp_q.size() == 0 && !bus.out_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("drain_timeout", 32'(ok), 32'd1);
   endtask

   task automatic clear_stats();
      @(negedge clk) stat_clr = 1'b1;
      @(negedge clk) stat_clr = 1'b0;
      #1 chk("clr_smp_cnt", 32'(smp_cnt), 32'd0);
   endtask

   // Monitor: samples mid-cycle, pops on every transfer that the next edge commits
   initial begin
      forever begin
         @(negedge clk); #2;
         if (!rst_n) begin
            stall = 1'b0;
         end else begin
            if (stall) begin
               chk("stall_valid_held", 32'(bus.out_valid), 32'd1);
               chk("stall_O_stable", 32'(bus.O), 32'(held));
            end
            if (bus.out_valid && bus.out_ready) begin
               if (exp_q.size() == 0) chk("unexpected_output", 32'(bus.O), 32'h1ff);
               else chk("O", 32'(bus.O), 32'(exp_q.pop_front()));
            end
            stall = bus.out_valid & ~bus.out_ready;
            held  = bus.O;
         end
      end
   end

   logic [7:0] va [8] = '{8'h01, 8'hFF, 8'h88, 8'hF0, 8'h3C, 8'h0A, 8'h7F, 8'h80};
   logic [7:0] vb [8] = '{8'h02, 8'hFF, 8'h88, 8'h10, 8'h05, 8'h05, 8'h81, 8'h80};
   logic [1:0] vm [8] = '{2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd1, 2'd2, 2'd0};
   logic [8:0] vo [8] = '{9'h003, 9'h1FE, 9'h118, 9'h100, 9'h035, 9'h00F, 9'h0F0, 9'h100};

   initial begin
      bus.A = '0; bus.B = '0; bus.mode = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b1;
      sbus.A = 8'h0F; sbus.B = 8'h01; sbus.mode = MODE_TRUNC;
      sbus.in_valid = 1'b0; sbus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #3 rst_n = 1'b1;
      @(negedge clk); #1;
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("rst_O", 32'(bus.O), 32'd0);
      chk("rst_err_sum", 32'(err_sum), 32'd0);
      chk("rst_err_max", 32'(err_max), 32'd0);
      chk("rst_smp_cnt", 32'(smp_cnt), 32'd0);

      // Exact mode
      send(8'd200, 8'd100, MODE_EXACT, 9'h12C);
      drain();
      chk("exact_smp_cnt", 32'(smp_cnt), 32'd1);
      chk("exact_err_cnt", 32'(err_cnt), 32'd0);
      chk("exact_err_sum", 32'(err_sum), 32'd0);

      // Approximate modes on 0x0F + 0x01
      clear_stats();
      send(8'h0F, 8'h01, MODE_LOA,   9'h00F);
      send(8'h0F, 8'h01, MODE_TRUNC, 9'h000);
      send(8'h0F, 8'h01, MODE_COPY,  9'h001);
      drain();
      chk("modes_err_max", 32'(err_max), 32'd16);
      chk("modes_err_sum", 32'(err_sum), 32'd32);
      chk("modes_err_cnt", 32'(err_cnt), 32'd3);
      chk("modes_smp_cnt", 32'(smp_cnt), 32'd3);

      // Clear coinciding with a transfer of error 5
      bus.out_ready = 1'b0;
      send(8'h05, 8'h00, MODE_COPY, 9'h000);
      for (int n = 0; n < 50; n++) begin
         @(negedge clk); #1;
         if (bus.out_valid) break;
      end
      chk("clr_wait_valid", 32'(bus.out_valid), 32'd1);
      stat_clr = 1'b1; bus.out_ready = 1'b1;
      @(posedge clk); #1 stat_clr = 1'b0;
      chk("clr_xfer_smp_cnt", 32'(smp_cnt), 32'd1);
      chk("clr_xfer_err_sum", 32'(err_sum), 32'd5);
      chk("clr_xfer_err_max", 32'(err_max), 32'd5);
      chk("clr_xfer_err_cnt", 32'(err_cnt), 32'd1);
      drain();

      // Backpressure stream with out_ready toggling and mixed modes
      clear_stats();
      stream_done = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) send(va[i], vb[i], vm[i], vo[i]);
            stream_done = 1'b1;
         end
         begin
            while (!stream_done) @(negedge clk) bus.out_ready = ~bus.out_ready;
         end
      join
      bus.out_ready = 1'b1;
      drain();
      chk("bp_smp_cnt", 32'(smp_cnt), 32'd8);
      chk("bp_err_sum", 32'(err_sum), 32'd36);
      chk("bp_err_cnt", 32'(err_cnt), 32'd3);
      chk("bp_err_max", 32'(err_max), 32'd16);

      // Reset with two transactions in flight
      bus.out_ready = 1'b0;
      send(8'h11, 8'h22, MODE_EXACT, 9'h033);
      send(8'h44, 8'h55, MODE_EXACT, 9'h099);
      @(negedge clk); #3 rst_n = 1'b0;
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      chk("midrst_smp_cnt", 32'(smp_cnt), 32'd0);
      chk("midrst_err_sum", 32'(err_sum), 32'd0);
      exp_q.delete();
      repeat (2) @(negedge clk);
      #3 rst_n = 1'b1;
      bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      #1 chk("postrst_no_stale", 32'(bus.out_valid), 32'd0);
      send(8'h10, 8'h20, MODE_EXACT, 9'h030);
      drain();
      chk("postrst_smp_cnt", 32'(smp_cnt), 32'd1);

      // Saturation with 4-bit counters
      @(negedge clk) sbus.in_valid = 1'b1;
      repeat (20) @(negedge clk);
      sbus.in_valid = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("sat_err_sum", 32'(s_err_sum), 32'd15);
      chk("sat_err_cnt", 32'(s_err_cnt), 32'd15);
      chk("sat_smp_cnt", 32'(s_smp_cnt), 32'd15);
      chk("sat_err_max", 32'(s_err_max), 32'd16);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
